// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register block's single write port between NUM_REQ requesters.
// Optional macro REG_ARB_PC_PRIORITY_EN: requests targeting register 12 (PC) win over round-robin order.
module reg_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_id,
  input  logic [8*NUM_REQ-1:0] req_value,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           write_id,
  output logic [7:0]           write_value,
  output logic                 busy,
  output logic                 drop
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [3:0] MAX_ID = 4'd12;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]       write_id_reg, write_id_next;
  logic [7:0]       write_value_reg, write_value_next;
  logic             drop_reg, drop_next;

  logic [3:0]         id_arr  [NUM_REQ];
  logic [7:0]         val_arr [NUM_REQ];
  logic [NUM_REQ-1:0] sel_mask;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               grant;
  logic               id_ok;
  int                 cand_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign id_arr[gi]  = req_id[4*gi +: 4];
      assign val_arr[gi] = req_value[8*gi +: 8];
    end
  endgenerate

`ifdef REG_ARB_PC_PRIORITY_EN
  logic [NUM_REQ-1:0] pc_hit;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pc
      assign pc_hit[gi] = req_valid[gi] && (id_arr[gi] == MAX_ID);
    end
  endgenerate
  // PC requests, when present, narrow the candidate set; round-robin still breaks ties.
  assign sel_mask = (|pc_hit) ? pc_hit : req_valid;
`else
  assign sel_mask = req_valid;
`endif

  // First candidate searching upward from the slot after the last grant, with wrap.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = (int'(last_grant_reg) + k) % NUM_REQ;
      if (!found && sel_mask[cand_idx]) begin
        found  = 1'b1;
        winner = IDX_W'(cand_idx);
      end
    end
  end

  // Gating with rst_n keeps ready low for the whole asynchronous reset window.
  assign grant = rst_n && (state_reg == IDLE) && found;
  assign id_ok = (id_arr[winner] != 4'd0) && (id_arr[winner] <= MAX_ID);

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    hold_cnt_next    = hold_cnt_reg;
    write_id_next    = write_id_reg;
    write_value_next = write_value_reg;
    drop_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        write_id_next = 4'd0;
        if (grant) begin
          last_grant_next = winner;
          if (id_ok) begin
            state_next       = DRIVE;
            write_id_next    = id_arr[winner];
            write_value_next = val_arr[winner];
            hold_cnt_next    = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            drop_next = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (hold_cnt_reg == '0) begin
          // Park on register 0: the block has no write enable.
          state_next    = IDLE;
          write_id_next = 4'd0;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        write_id_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      last_grant_reg  <= IDX_W'(NUM_REQ - 1);
      hold_cnt_reg    <= '0;
      write_id_reg    <= 4'd0;
      write_value_reg <= 8'd0;
      drop_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      hold_cnt_reg    <= hold_cnt_next;
      write_id_reg    <= write_id_next;
      write_value_reg <= write_value_next;
      drop_reg        <= drop_next;
    end
  end

  assign write_id    = write_id_reg;
  assign write_value = write_value_reg;
  assign busy        = (state_reg == DRIVE);
  assign drop        = drop_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (NUM_REQ=4, HOLD_CYCLES=2): vector tables plus
// hand-written reset, fairness and PC-priority sequences, all checked through an expectation queue.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_id = '0;
  logic [31:0] req_value = '0;
  logic [3:0]  req_ready;
  logic [3:0]  write_id;
  logic [7:0]  write_value;
  logic        busy;
  logic        drop;

  reg_write_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_id(req_id), .req_value(req_value),
    .req_ready(req_ready), .write_id(write_id), .write_value(write_value),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic [3:0]  valid;
    logic [15:0] ids;
    logic [31:0] vals;
    logic [3:0]  ready;
    logic [3:0]  wid;
    logic [7:0]  wval;
    logic        busy;
    logic        drop;
  } vec_t;

  typedef struct {
    logic [3:0] ready;
    logic [3:0] wid;
    logic [7:0] wval;
    logic       busy;
    logic       drop;
  } exp_t;

  localparam int NV = 16;
  vec_t vt [NV];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Assert reset with the given requests already presented; returns at the start of cycle 0.
  task automatic do_reset(input logic [3:0] v, input logic [15:0] ids, input logic [31:0] vals);
    req_valid = v;
    req_id    = ids;
    req_value = vals;
    rst_n     = 1'b0;
    #1;
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset write_id", 32'(write_id), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_seg(input int s);
    exp_t e;
    int   c;
    c = 0;
    for (int i = 0; i < NV; i++) begin
      if (vt[i].seg == s) begin
        req_valid = vt[i].valid;
        req_id    = vt[i].ids;
        req_value = vt[i].vals;
        sb.push_back('{vt[i].ready, vt[i].wid, vt[i].wval, vt[i].busy, vt[i].drop});
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("seg%0d.c%0d ready", s, c), 32'(req_ready), 32'(e.ready));
        chk($sformatf("seg%0d.c%0d write_id", s, c), 32'(write_id), 32'(e.wid));
        chk($sformatf("seg%0d.c%0d write_value", s, c), 32'(write_value), 32'(e.wval));
        chk($sformatf("seg%0d.c%0d busy", s, c), 32'(busy), 32'(e.busy));
        chk($sformatf("seg%0d.c%0d drop", s, c), 32'(drop), 32'(e.drop));
        c++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    exp_t pend;
    logic pending;
    int   grants [4];
    int   cyc;

    // seg 1: single write by req 1, then invalid id from req 3 with req 0 queued.
    vt[0]  = '{1, 4'b0010, 16'h0030, 32'h0000A500, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1, 4'b0000, 16'h0030, 32'h0000A500, 4'b0000, 4'h3, 8'hA5, 1'b1, 1'b0};
    vt[2]  = '{1, 4'b0000, 16'h0030, 32'h0000A500, 4'b0000, 4'h3, 8'hA5, 1'b1, 1'b0};
    vt[3]  = '{1, 4'b0000, 16'h0030, 32'h0000A500, 4'b0000, 4'h0, 8'hA5, 1'b0, 1'b0};
    vt[4]  = '{1, 4'b1001, 16'hE007, 32'hFF00003C, 4'b1000, 4'h0, 8'hA5, 1'b0, 1'b0};
    vt[5]  = '{1, 4'b0001, 16'hE007, 32'hFF00003C, 4'b0001, 4'h0, 8'hA5, 1'b0, 1'b1};
    vt[6]  = '{1, 4'b0000, 16'hE007, 32'hFF00003C, 4'b0000, 4'h7, 8'h3C, 1'b1, 1'b0};
    vt[7]  = '{1, 4'b0000, 16'hE007, 32'hFF00003C, 4'b0000, 4'h7, 8'h3C, 1'b1, 1'b0};
    vt[8]  = '{1, 4'b0000, 16'hE007, 32'hFF00003C, 4'b0000, 4'h0, 8'h3C, 1'b0, 1'b0};
    // seg 2: req 0 and req 2 valid from reset.
    vt[9]  = '{2, 4'b0101, 16'h0605, 32'h00220011, 4'b0001, 4'h0, 8'h00, 1'b0, 1'b0};
    vt[10] = '{2, 4'b0100, 16'h0605, 32'h00220011, 4'b0000, 4'h5, 8'h11, 1'b1, 1'b0};
    vt[11] = '{2, 4'b0100, 16'h0605, 32'h00220011, 4'b0000, 4'h5, 8'h11, 1'b1, 1'b0};
    vt[12] = '{2, 4'b0100, 16'h0605, 32'h00220011, 4'b0100, 4'h0, 8'h11, 1'b0, 1'b0};
    vt[13] = '{2, 4'b0000, 16'h0605, 32'h00220011, 4'b0000, 4'h6, 8'h22, 1'b1, 1'b0};
    vt[14] = '{2, 4'b0000, 16'h0605, 32'h00220011, 4'b0000, 4'h6, 8'h22, 1'b1, 1'b0};
    vt[15] = '{2, 4'b0000, 16'h0605, 32'h00220011, 4'b0000, 4'h0, 8'h22, 1'b0, 1'b0};

    do_reset(4'b0000, 16'h0, 32'h0);
    run_seg(1);

    do_reset(4'b0101, 16'h0605, 32'h00220011);
    run_seg(2);

    // Reset mid-DRIVE: last grant was req 2, so without reset req 3 would win next.
    req_valid = 4'b0100;
    req_id    = 16'h0900;
    req_value = 32'h005A0000;
    @(negedge clk);
    chk("middrive grant", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'b1001;
    req_id    = 16'h8002;
    req_value = 32'h83000021;
    #2;
    chk("middrive write_id before reset", 32'(write_id), 32'h9);
    chk("middrive busy before reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async reset write_id", 32'(write_id), 32'h0);
    chk("async reset write_value", 32'(write_value), 32'h0);
    chk("async reset busy", 32'(busy), 32'h0);
    chk("async reset ready", 32'(req_ready), 32'h0);
    chk("async reset drop", 32'(drop), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset priority", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;

    // Fairness: all four continuously valid; expect 0,1,2,3 repeating.
    do_reset(4'hF, 16'h4321, 32'h44332211);
    for (int g = 0; g < 12; g++) begin
      e.ready = 4'b0001 << (g % 4);
      e.wid   = 4'((g % 4) + 1);
      e.wval  = 8'(8'h11 * ((g % 4) + 1));
      e.busy  = 1'b1;
      e.drop  = 1'b0;
      sb.push_back(e);
    end
    for (int j = 0; j < 4; j++) grants[j] = 0;
    pending = 1'b0;
    pend    = '{4'h0, 4'h0, 8'h00, 1'b0, 1'b0};
    cyc     = 0;
    while (cyc < 100 && (sb.size() > 0 || pending)) begin
      @(negedge clk);
      if (pending) begin
        chk($sformatf("fair write_id c%0d", cyc), 32'(write_id), 32'(pend.wid));
        chk($sformatf("fair write_value c%0d", cyc), 32'(write_value), 32'(pend.wval));
        chk($sformatf("fair busy c%0d", cyc), 32'(busy), 32'(pend.busy));
        pending = 1'b0;
      end
      if (req_ready != 4'b0000 && sb.size() > 0) begin
        pend = sb.pop_front();
        chk($sformatf("fair grant c%0d", cyc), 32'(req_ready), 32'(pend.ready));
        pending = 1'b1;
        for (int j = 0; j < 4; j++) if (req_ready[j]) grants[j]++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("fair grants outstanding", 32'(sb.size()), 32'h0);
    sb.delete();
    for (int j = 0; j < 4; j++) chk($sformatf("fair count req%0d", j), 32'(grants[j]), 32'd3);

    // req 0 (id 4) and req 1 (id 12 = PC) valid from reset.
    do_reset(4'b0011, 16'h00C4, 32'h0000C140);
    @(negedge clk);
`ifdef REG_ARB_PC_PRIORITY_EN
    chk("pc priority grant", 32'(req_ready), 32'h2);
`else
    chk("round-robin ignores id", 32'(req_ready), 32'h1);
`endif
    @(posedge clk);
    #1;
    req_valid = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
